// File: rtl/uart_rx_if.sv
// Byte-side bundle of the UART receiver: serial line in, recovered byte and status out.
// Latency: none, wires only.
// Backpressure: none; the sink must accept rx_data in the cycle rx_valid is high.
//
// Signals:
//   rx            serial line into the receiver (idle high, asynchronous)
//   rx_data       last good byte, held until the next good frame
//   rx_valid      one-cycle pulse when rx_data is updated
//   framing_error one-cycle pulse when a stop bit is sampled low
//   busy          receiver is inside a frame (any state but IDLE)
// Modports: master = receiver side, slave = line driver / byte sink side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 framing_error;
  logic                 busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output framing_error,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  framing_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: recovers N-data-bit, no-parity, one-stop-bit frames (LSB first) from rx.
// Latency: falling start edge to rx_valid = 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles.
// Backpressure: none; a new good frame overwrites rx_data, the sink takes it on rx_valid.
//
// Ports:
//   clk   system clock, rising edge
//   nrst  asynchronous active-low reset; a reset mid-frame abandons the frame silently
//   bus   uart_rx_if.master: rx in; rx_data, rx_valid, framing_error, busy out
// CLKS_PER_BIT must be even and >= 4; DATA_BITS must be in 1..8.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      nrst,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [DATA_BITS:0]   shift_cat;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 framing_error_q;
  logic                 busy_q;

  // New bit enters at the MSB and everything moves toward bit 0, so the first
  // bit on the wire ends up as the LSB. Done through a concatenation so that
  // DATA_BITS=1 needs no special case.
  always_comb begin
    shift_cat  = {rx_s, shift_reg};
    shift_next = shift_cat[DATA_BITS:1];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1           <= 1'b1;
      rx_s            <= 1'b1;
      state           <= IDLE;
      cnt             <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      // Two-flop synchroniser; everything below looks only at rx_s.
      sync1 <= bus.rx;
      rx_s  <= sync1;

      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;

      // Free-running bit-period counter. Every state transition below happens
      // either at the wrap point or from a state that holds it at zero, so it
      // always restarts from 0 in the new state.
      cnt <= (cnt == FULL_M1) ? '0 : cnt + CW'(1);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          // Leaving here at mid stop bit puts us in IDLE early enough to catch
          // a start edge that immediately follows the stop bit.
          if (cnt == FULL_M1) begin
            if (rx_s) begin
              rx_data_q  <= shift_reg;
              rx_valid_q <= 1'b1;
              state      <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              framing_error_q <= 1'b1;
              state           <= BREAK;
            end
          end
        end

        BREAK: begin
          // A line held low would otherwise look like an endless run of start bits.
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16, DATA_BITS=8.
// Table of good frames with expected byte and latency, plus hand sequences for
// reset idle, glitch rejection, framing error / break, and reset mid-frame.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;  // 155

  logic clk;
  logic nrst;

  uart_rx_if #(.DATA_BITS(8)) u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         valid_cnt = 0;
  int         fe_cnt    = 0;
  int         both_cnt  = 0;
  int         idle_bad  = 0;
  bit         idle_watch = 1'b0;
  logic [7:0] last_data = 8'h00;
  int         last_lat  = -1;
  int         start_cyc = 0;

  always @(negedge clk) begin
    if (u_if.rx_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      last_data = u_if.rx_data;
      last_lat  = cyc - start_cyc;
    end
    if (u_if.framing_error === 1'b1) fe_cnt = fe_cnt + 1;
    if (u_if.rx_valid === 1'b1 && u_if.framing_error === 1'b1) both_cnt = both_cnt + 1;
    if (idle_watch && (u_if.busy !== 1'b0 || u_if.rx_valid !== 1'b0 || u_if.rx_data !== 8'h00))
      idle_bad = idle_bad + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame, LSB first, 16 cycles per bit; leaves rx at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    u_if.rx   = 1'b0;
    start_cyc = cyc;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      wait_cyc(CPB);
    end
    u_if.rx = stop;
    wait_cyc(CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    int         gap;       // idle-high cycles after the frame; 0 = back-to-back
    int         exp_inc;   // rx_valid pulses expected for this frame
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  int v0, f0;
  logic [7:0] d0;

  initial begin
    vecs[0] = '{data: 8'hA5, gap: 20, exp_inc: 1, exp_data: 8'hA5, exp_lat: 155};
    vecs[1] = '{data: 8'h3C, gap: 0,  exp_inc: 1, exp_data: 8'h3C, exp_lat: 155};
    vecs[2] = '{data: 8'hFF, gap: 20, exp_inc: 1, exp_data: 8'hFF, exp_lat: 155};
    vecs[3] = '{data: 8'h00, gap: 0,  exp_inc: 1, exp_data: 8'h00, exp_lat: 155};
    vecs[4] = '{data: 8'h80, gap: 0,  exp_inc: 1, exp_data: 8'h80, exp_lat: 155};
    vecs[5] = '{data: 8'h01, gap: 30, exp_inc: 1, exp_data: 8'h01, exp_lat: 155};

    // Reset and idle line.
    nrst    = 1'b0;
    u_if.rx = 1'b1;
    wait_cyc(5);
    check("reset_busy", int'(u_if.busy), 0);
    check("reset_valid", int'(u_if.rx_valid), 0);
    check("reset_data", int'(u_if.rx_data), 0);
    nrst = 1'b1;
    idle_watch = 1'b1;
    wait_cyc(100);
    idle_watch = 1'b0;
    check("idle_100_cycles_bad_samples", idle_bad, 0);

    // Good frames from the table, including back-to-back pairs.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      send_frame(vecs[i].data, 1'b1);
      check($sformatf("vec%0d_pulses", i), valid_cnt - v0, vecs[i].exp_inc);
      check($sformatf("vec%0d_data", i), int'(last_data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_latency", i), last_lat, vecs[i].exp_lat);
      if (vecs[i].gap > 0) wait_cyc(vecs[i].gap);
    end
    check("latency_formula", last_lat, LAT);

    // Short low glitch: busy rises, then START rejects it.
    v0 = valid_cnt;
    f0 = fe_cnt;
    u_if.rx = 1'b0;
    wait_cyc(5);
    check("glitch_busy_high", int'(u_if.busy), 1);
    u_if.rx = 1'b1;
    wait_cyc(30);
    check("glitch_busy_low", int'(u_if.busy), 0);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_fe", fe_cnt - f0, 0);

    // Bad stop bit, line held low, then a good frame.
    v0 = valid_cnt;
    f0 = fe_cnt;
    d0 = u_if.rx_data;
    send_frame(8'h81, 1'b0);
    wait_cyc(50);
    check("fe_one_pulse", fe_cnt - f0, 1);
    check("fe_no_valid", valid_cnt - v0, 0);
    check("fe_data_held", int'(u_if.rx_data), int'(d0));
    check("break_busy_high", int'(u_if.busy), 1);
    u_if.rx = 1'b1;
    wait_cyc(20);
    check("break_exit_busy_low", int'(u_if.busy), 0);
    send_frame(8'h42, 1'b1);
    check("after_break_pulses", valid_cnt - v0, 1);
    check("after_break_data", int'(last_data), 8'h42);
    wait_cyc(20);

    // Reset during the data bits of 0x55, then 0x0F.
    v0 = valid_cnt;
    u_if.rx   = 1'b0;
    start_cyc = cyc;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      u_if.rx = i[0];  // 0x55 LSB-first: 1,0,1,0
      u_if.rx = ~u_if.rx;
      wait_cyc(CPB);
    end
    nrst    = 1'b0;
    u_if.rx = 1'b1;
    wait_cyc(3);
    check("midreset_busy", int'(u_if.busy), 0);
    check("midreset_data", int'(u_if.rx_data), 0);
    nrst = 1'b1;
    wait_cyc(200);
    check("midreset_no_pulse", valid_cnt - v0, 0);
    send_frame(8'h0F, 1'b1);
    check("post_reset_pulses", valid_cnt - v0, 1);
    check("post_reset_data", int'(u_if.rx_data), 8'h0F);
    wait_cyc(20);

    check("valid_and_fe_overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
